// File: rtl/mc_controller.sv
// mc_controller: multicycle MIPS control FSM with memory-ready handshake and stall timeout.
// Optional macro MC_ILLEGAL_TRAP_EN: undefined opcodes enter a sticky TRAP state that
// raises illegal_op; without it an undefined opcode retires as a two-cycle NOP.
module mc_controller #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       pcwrite,
  output logic       branch,
  output logic       bne,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       zeroext,
  output logic [1:0] aluop,
  output logic [1:0] pcsrc,
  output logic       instr_done,
  output logic       mem_timeout
`ifdef MC_ILLEGAL_TRAP_EN
  ,
  output logic       illegal_op
`endif
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXECUTE,
    S_ALUWB,
    S_BEQ,
    S_BNE,
    S_ADDIEX,
    S_ORIEX,
    S_IWB,
    S_JUMP
`ifdef MC_ILLEGAL_TRAP_EN
    ,
    S_TRAP
`endif
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             wait_st;
  logic             timeout_hit;

  // State register and memory wait counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FETCH;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state and Moore output decode, with timeout abort and reset masking last
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = '0;
    iord        = 1'b0;
    memwrite    = 1'b0;
    irwrite     = 1'b0;
    pcwrite     = 1'b0;
    branch      = 1'b0;
    bne         = 1'b0;
    regdst      = 1'b0;
    memtoreg    = 1'b0;
    regwrite    = 1'b0;
    alusrca     = 1'b0;
    alusrcb     = 2'b00;
    zeroext     = 1'b0;
    aluop       = 2'b00;
    pcsrc       = 2'b00;
    instr_done  = 1'b0;
    mem_timeout = 1'b0;
`ifdef MC_ILLEGAL_TRAP_EN
    illegal_op  = 1'b0;
`endif

    wait_st     = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
    timeout_hit = wait_st && !mem_ready && (MEM_TIMEOUT != 0) &&
                  (cnt == CNT_W'(MEM_TIMEOUT));
    if (wait_st && !mem_ready) begin
      cnt_nxt = cnt + CNT_W'(1);
    end

    case (state)
      S_FETCH: begin
        alusrcb = 2'b01;
        irwrite = mem_ready;
        pcwrite = mem_ready;
        if (mem_ready) begin
          state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW: state_nxt = S_MEMADR;
          OP_RTYPE:     state_nxt = S_EXECUTE;
          OP_BEQ:       state_nxt = S_BEQ;
          OP_BNE:       state_nxt = S_BNE;
          OP_ADDI:      state_nxt = S_ADDIEX;
          OP_ORI:       state_nxt = S_ORIEX;
          OP_J:         state_nxt = S_JUMP;
          default: begin
`ifdef MC_ILLEGAL_TRAP_EN
            state_nxt  = S_TRAP;
`else
            state_nxt  = S_FETCH;
            instr_done = 1'b1;
`endif
          end
        endcase
      end
      S_MEMADR: begin
        alusrca   = 1'b1;
        alusrcb   = 2'b10;
        state_nxt = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        iord = 1'b1;
        if (mem_ready) begin
          state_nxt = S_MEMWB;
        end
      end
      S_MEMWB: begin
        memtoreg   = 1'b1;
        regwrite   = 1'b1;
        instr_done = 1'b1;
        state_nxt  = S_FETCH;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_nxt  = S_FETCH;
        end
      end
      S_EXECUTE: begin
        alusrca   = 1'b1;
        aluop     = 2'b10;
        state_nxt = S_ALUWB;
      end
      S_ALUWB: begin
        regdst     = 1'b1;
        regwrite   = 1'b1;
        instr_done = 1'b1;
        state_nxt  = S_FETCH;
      end
      S_BEQ: begin
        alusrca    = 1'b1;
        aluop      = 2'b01;
        pcsrc      = 2'b01;
        branch     = 1'b1;
        instr_done = 1'b1;
        state_nxt  = S_FETCH;
      end
      S_BNE: begin
        alusrca    = 1'b1;
        aluop      = 2'b01;
        pcsrc      = 2'b01;
        bne        = 1'b1;
        instr_done = 1'b1;
        state_nxt  = S_FETCH;
      end
      S_ADDIEX: begin
        alusrca   = 1'b1;
        alusrcb   = 2'b10;
        state_nxt = S_IWB;
      end
      S_ORIEX: begin
        alusrca   = 1'b1;
        alusrcb   = 2'b10;
        aluop     = 2'b11;
        zeroext   = 1'b1;
        state_nxt = S_IWB;
      end
      S_IWB: begin
        regwrite   = 1'b1;
        instr_done = 1'b1;
        state_nxt  = S_FETCH;
      end
      S_JUMP: begin
        pcsrc      = 2'b10;
        pcwrite    = 1'b1;
        instr_done = 1'b1;
        state_nxt  = S_FETCH;
      end
`ifdef MC_ILLEGAL_TRAP_EN
      S_TRAP: begin
        illegal_op = 1'b1;
        state_nxt  = S_TRAP;
      end
`endif
      default: state_nxt = S_FETCH;
    endcase

    // A stalled access that hits the limit is abandoned with no side effects
    if (timeout_hit) begin
      state_nxt   = S_FETCH;
      cnt_nxt     = '0;
      memwrite    = 1'b0;
      irwrite     = 1'b0;
      pcwrite     = 1'b0;
      regwrite    = 1'b0;
      branch      = 1'b0;
      bne         = 1'b0;
      instr_done  = 1'b0;
      mem_timeout = 1'b1;
    end

    // Reset blocks every side effect in the cycle it is asserted
    if (reset) begin
      memwrite    = 1'b0;
      irwrite     = 1'b0;
      pcwrite     = 1'b0;
      regwrite    = 1'b0;
      branch      = 1'b0;
      bne         = 1'b0;
      instr_done  = 1'b0;
      mem_timeout = 1'b0;
    end
  end

endmodule
